// File: rtl/pa_fpu.sv
// Shared fpu definitions: operation codes, the bus-interface register map,
// STATUS bit positions and the bus-interface FSM states.
package pa_fpu;

    typedef enum logic [3:0] {
        FPU_ADD  = 4'd0,
        FPU_SUB  = 4'd1,
        FPU_MUL  = 4'd2,
        FPU_DIV  = 4'd3,
        FPU_SQRT = 4'd4,
        FPU_CMP  = 4'd5,
        FPU_ITOF = 4'd6,
        FPU_FTOI = 4'd7
    } e_fpu_op;

    localparam logic [3:0] ADDR_A0     = 4'd0;
    localparam logic [3:0] ADDR_A1     = 4'd1;
    localparam logic [3:0] ADDR_A2     = 4'd2;
    localparam logic [3:0] ADDR_A3     = 4'd3;
    localparam logic [3:0] ADDR_B0     = 4'd4;
    localparam logic [3:0] ADDR_B1     = 4'd5;
    localparam logic [3:0] ADDR_B2     = 4'd6;
    localparam logic [3:0] ADDR_B3     = 4'd7;
    localparam logic [3:0] ADDR_R0     = 4'd8;
    localparam logic [3:0] ADDR_R1     = 4'd9;
    localparam logic [3:0] ADDR_R2     = 4'd10;
    localparam logic [3:0] ADDR_R3     = 4'd11;
    localparam logic [3:0] ADDR_CMD    = 4'd12;
    localparam logic [3:0] ADDR_STATUS = 4'd13;

    localparam int CMD_GO_BIT = 7;

    localparam int ST_DONE    = 0;
    localparam int ST_TIMEOUT = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_IRQ_EN  = 3;
    localparam int ST_BUSY    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } e_fpu_if_state;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fpu_if_regs.sv
// Byte-addressed operand, result, command and status registers with the
// combinational read mux, write-one-to-clear flags and the registered irq.
module fpu_if_regs
    import pa_fpu::*;
#(
    parameter int OP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                cs,
    input  logic                wr,
    input  logic                rd,
    input  logic [3:0]          addr,
    input  logic [7:0]          data_in,
    output logic [7:0]          data_out,
    input  logic                busy,
    input  logic                complete,
    input  logic                expire,
    input  logic [31:0]         result,
    output logic                go,
    output logic [31:0]         a,
    output logic [31:0]         b,
    output logic [OP_WIDTH-1:0] op,
    output logic                irq
);

    logic [31:0] r;
    logic        done;
    logic        timeout;
    logic        err;
    logic        irq_en;
    logic [7:0]  status;

    logic wr_en;
    logic wr_a;
    logic wr_b;
    logic wr_cmd;
    logic wr_status;
    logic blocked;

    assign wr_en     = cs & wr;
    assign wr_a      = wr_en & (addr[3:2] == ADDR_A0[3:2]);
    assign wr_b      = wr_en & (addr[3:2] == ADDR_B0[3:2]);
    assign wr_cmd    = wr_en & (addr == ADDR_CMD);
    assign wr_status = wr_en & (addr == ADDR_STATUS);

    // Operand and command writes are refused while a command is in flight.
    assign blocked = busy & (wr_a | wr_b | wr_cmd);
    assign go      = wr_cmd & ~busy & data_in[CMD_GO_BIT];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            a       <= '0;
            b       <= '0;
            r       <= '0;
            op      <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            err     <= 1'b0;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_a && !busy) begin
                a[{addr[1:0], 3'b000} +: 8] <= data_in;
            end
            if (wr_b && !busy) begin
                b[{addr[1:0], 3'b000} +: 8] <= data_in;
            end
            if (wr_cmd && !busy) begin
                op <= data_in[OP_WIDTH-1:0];
            end
            if (complete) begin
                r <= result;
            end
            if (wr_status) begin
                done    <= done & ~data_in[ST_DONE];
                timeout <= timeout & ~data_in[ST_TIMEOUT];
                err     <= err & ~data_in[ST_ERR];
                irq_en  <= data_in[ST_IRQ_EN];
            end
            if (go) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end
            // Setting events come last so they beat a same-cycle W1C.
            if (complete || expire) begin
                done <= 1'b1;
            end
            if (expire) begin
                timeout <= 1'b1;
            end
            if (blocked) begin
                err <= 1'b1;
            end
            irq <= done & irq_en;
        end
    end

    always_comb begin
        status            = 8'h00;
        status[ST_DONE]    = done;
        status[ST_TIMEOUT] = timeout;
        status[ST_ERR]     = err;
        status[ST_IRQ_EN]  = irq_en;
        status[ST_BUSY]    = busy;
    end

    always_comb begin
        data_out = 8'h00;
        if (cs && rd) begin
            case (addr)
                ADDR_A0:     data_out = word_byte(a, 2'd0);
                ADDR_A1:     data_out = word_byte(a, 2'd1);
                ADDR_A2:     data_out = word_byte(a, 2'd2);
                ADDR_A3:     data_out = word_byte(a, 2'd3);
                ADDR_B0:     data_out = word_byte(b, 2'd0);
                ADDR_B1:     data_out = word_byte(b, 2'd1);
                ADDR_B2:     data_out = word_byte(b, 2'd2);
                ADDR_B3:     data_out = word_byte(b, 2'd3);
                ADDR_R0:     data_out = word_byte(r, 2'd0);
                ADDR_R1:     data_out = word_byte(r, 2'd1);
                ADDR_R2:     data_out = word_byte(r, 2'd2);
                ADDR_R3:     data_out = word_byte(r, 2'd3);
                ADDR_STATUS: data_out = status;
                default:     data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/fpu_bus_interface.sv
// CPU byte-bus front end for the fpu: launches a command, holds start until
// cmd_end or timeout, then drains until the fpu has gone quiet.
module fpu_bus_interface
    import pa_fpu::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OP_WIDTH       = 4
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          cs,
    input  logic          wr,
    input  logic          rd,
    input  logic [3:0]    addr,
    input  logic [7:0]    data_in,
    output logic [7:0]    data_out,
    output logic          irq,
    output logic [31:0]   fpu_a_operand,
    output logic [31:0]   fpu_b_operand,
    output e_fpu_op       fpu_operation,
    output logic          fpu_start,
    input  logic [31:0]   fpu_result,
    input  logic          fpu_cmd_end,
    input  logic          fpu_busy,
    output e_fpu_if_state state
);

    localparam int          OP_BITS    = $bits(e_fpu_op);
    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0]         count;
    logic [OP_WIDTH-1:0] op;
    logic                go;
    logic                complete;
    logic                expire;
    logic                busy;

    assign busy     = (state != IDLE);
    assign complete = (state == RUN) & fpu_cmd_end;
    // cmd_end in the final counted cycle still counts as a completion.
    assign expire   = (state == RUN) & ~fpu_cmd_end & (count == LAST_COUNT);

    assign fpu_operation = e_fpu_op'(OP_BITS'(op));

    fpu_if_regs #(
        .OP_WIDTH (OP_WIDTH)
    ) u_regs (
        .clk      (clk),
        .arst     (arst),
        .cs       (cs),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .complete (complete),
        .expire   (expire),
        .result   (fpu_result),
        .go       (go),
        .a        (fpu_a_operand),
        .b        (fpu_b_operand),
        .op       (op),
        .irq      (irq)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            count     <= '0;
            fpu_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= RUN;
                        count     <= '0;
                        fpu_start <= 1'b1;
                    end
                end
                RUN: begin
                    count <= count + 16'd1;
                    if (complete || expire) begin
                        state     <= DRAIN;
                        fpu_start <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Wait for the fpu to drop end and busy before accepting a new go.
                    if (!fpu_cmd_end && !fpu_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    fpu_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_bus_interface.sv
// Bench for fpu_bus_interface: vector table, hand-written corner sequences and
// randomized commands against a byte-level register model.
module tb_fpu_bus_interface;
    import pa_fpu::*;

    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          arst;
    logic          cs;
    logic          wr;
    logic          rd;
    logic [3:0]    addr;
    logic [7:0]    data_in;
    logic [7:0]    data_out;
    logic          irq;
    logic [31:0]   fpu_a_operand;
    logic [31:0]   fpu_b_operand;
    e_fpu_op       fpu_operation;
    logic          fpu_start;
    logic [31:0]   fpu_result;
    logic          fpu_cmd_end;
    logic          fpu_busy;
    e_fpu_if_state state;

    always #5 clk = ~clk;

    fpu_bus_interface #(
        .TIMEOUT_CYCLES (TO),
        .OP_WIDTH       (4)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .cs            (cs),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .data_in       (data_in),
        .data_out      (data_out),
        .irq           (irq),
        .fpu_a_operand (fpu_a_operand),
        .fpu_b_operand (fpu_b_operand),
        .fpu_operation (fpu_operation),
        .fpu_start     (fpu_start),
        .fpu_result    (fpu_result),
        .fpu_cmd_end   (fpu_cmd_end),
        .fpu_busy      (fpu_busy),
        .state         (state)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        int          lat;
        int          hold;
        logic        irq_en;
        logic [7:0]  exp_status;
        logic [31:0] exp_r;
        int          exp_start;
    } vec_t;

    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rb;
    logic [31:0] rw;
    int          sc;
    logic        irq0;
    logic        irq1;
    logic [7:0]  mem_m[8];
    logic [31:0] r_m;
    logic [3:0]  op_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = data_out;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic read_word(input logic [3:0] base, output logic [31:0] w);
        logic [7:0] bt;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            bus_read(base + 4'(k), bt);
            w[k*8 +: 8] = bt;
        end
    endtask

    // fpu model: answers after lat cycles unless start has already dropped,
    // then keeps busy for hold cycles. sc counts sampled cycles with start high.
    task automatic run_fpu(input int lat, input int hold, input logic [31:0] res,
                           output int cnt, output logic i0, output logic i1);
        int n = 0;
        fpu_busy = 1'b1;
        cnt = int'(fpu_start);
        while (n < lat && fpu_start) begin
            @(negedge clk);
            n++;
            cnt += int'(fpu_start);
        end
        if (fpu_start) begin
            fpu_result  = res;
            fpu_cmd_end = 1'b1;
            @(negedge clk);
            fpu_cmd_end = 1'b0;
            cnt += int'(fpu_start);
        end
        i0 = irq;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cnt += int'(fpu_start);
        end
        fpu_busy = 1'b0;
        @(negedge clk);
        cnt += int'(fpu_start);
        i1 = irq;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h3f800000, 32'h3f8ccccd, 4'd0, 32'h40066666, 3,  0, 1'b1, 8'h09, 32'h40066666, 4};
        vecs[1] = '{32'h40000000, 32'h40400000, 4'd2, 32'h40c00000, 0,  2, 1'b0, 8'h01, 32'h40c00000, 1};
        vecs[2] = '{32'h40400000, 32'h3f800000, 4'd1, 32'h40000000, 15, 1, 1'b0, 8'h01, 32'h40000000, 16};
        vecs[3] = '{32'h12345678, 32'h9abcdef0, 4'd3, 32'hdeadbeef, 40, 0, 1'b1, 8'h0b, 32'h40000000, 16};
        vecs[4] = '{32'h00000000, 32'hffffffff, 4'd4, 32'hcafef00d, 16, 1, 1'b0, 8'h03, 32'h40000000, 16};
        vecs[5] = '{32'h41200000, 32'h40000000, 4'd3, 32'h40a00000, 7,  3, 1'b1, 8'h09, 32'h40a00000, 8};

        arst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0;
        fpu_result = '0; fpu_cmd_end = 1'b0; fpu_busy = 1'b0;
        repeat (2) @(negedge clk);
        arst = 1'b0;

        // reset state
        check("reset_start", 32'(fpu_start), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_op", 32'(fpu_operation), 32'd0);
        check("reset_a", fpu_a_operand, 32'd0);
        check("reset_b", fpu_b_operand, 32'd0);
        check("reset_state", 32'(state), 32'(IDLE));
        for (int k = 0; k < 16; k++) begin
            bus_read(4'(k), rb);
            check($sformatf("reset_read_%0d", k), 32'(rb), 32'd0);
        end
        check("idle_read_data", 32'(data_out), 32'd0);

        // table-driven commands
        foreach (vecs[i]) begin
            bus_write(ADDR_STATUS, {4'b0000, vecs[i].irq_en, 3'b111});
            for (int k = 0; k < 4; k++) bus_write(ADDR_A0 + 4'(k), vecs[i].a[k*8 +: 8]);
            for (int k = 0; k < 4; k++) bus_write(ADDR_B0 + 4'(k), vecs[i].b[k*8 +: 8]);
            check($sformatf("vec%0d_a_operand", i), fpu_a_operand, vecs[i].a);
            check($sformatf("vec%0d_b_operand", i), fpu_b_operand, vecs[i].b);
            bus_write(ADDR_CMD, {4'b1000, vecs[i].op});
            check($sformatf("vec%0d_operation", i), 32'(fpu_operation), 32'(vecs[i].op));
            run_fpu(vecs[i].lat, vecs[i].hold, vecs[i].res, sc, irq0, irq1);
            check($sformatf("vec%0d_start_cycles", i), 32'(sc), 32'(vecs[i].exp_start));
            check($sformatf("vec%0d_irq_lag", i), 32'(irq0), 32'd0);
            check($sformatf("vec%0d_irq", i), 32'(irq1), 32'(vecs[i].irq_en));
            read_word(ADDR_R0, rw);
            check($sformatf("vec%0d_result", i), rw, vecs[i].exp_r);
            bus_read(ADDR_STATUS, rb);
            check($sformatf("vec%0d_status", i), 32'(rb), 32'(vecs[i].exp_status));
        end

        // busy write during RUN is dropped and flags err
        bus_write(ADDR_STATUS, 8'h07);
        bus_write(ADDR_CMD, 8'h80);
        fpu_busy = 1'b1;
        bus_write(ADDR_A0, 8'hff);
        fpu_result = 32'h11112222; fpu_cmd_end = 1'b1;
        @(negedge clk);
        fpu_cmd_end = 1'b0; fpu_busy = 1'b0;
        @(negedge clk);
        read_word(ADDR_A0, rw);
        check("busy_a_kept", rw, 32'h41200000);
        bus_read(ADDR_STATUS, rb);
        check("busy_status", 32'(rb), 32'h05);
        read_word(ADDR_R0, rw);
        check("busy_result", rw, 32'h11112222);

        // W1C of done in the cycle cmd_end is first sampled
        bus_write(ADDR_STATUS, 8'h0f);
        bus_write(ADDR_CMD, 8'h82);
        fpu_busy = 1'b1;
        @(negedge clk);
        fpu_result = 32'h33334444; fpu_cmd_end = 1'b1;
        bus_write(ADDR_STATUS, 8'h09);
        fpu_cmd_end = 1'b0; fpu_busy = 1'b0;
        @(negedge clk);
        check("race_irq", 32'(irq), 32'd1);
        bus_read(ADDR_STATUS, rb);
        check("race_status", 32'(rb), 32'h09);
        check("race_irq_held", 32'(irq), 32'd1);
        bus_write(ADDR_STATUS, 8'h09);
        @(negedge clk);
        check("race_irq_cleared", 32'(irq), 32'd0);
        bus_read(ADDR_STATUS, rb);
        check("race_status_cleared", 32'(rb), 32'h08);

        // fpu stays busy after cmd_end: hold in DRAIN, refuse a new command
        bus_write(ADDR_STATUS, 8'h07);
        bus_write(ADDR_CMD, 8'h83);
        fpu_busy = 1'b1;
        @(negedge clk);
        fpu_result = 32'h55556666; fpu_cmd_end = 1'b1;
        @(negedge clk);
        fpu_cmd_end = 1'b0;
        bus_read(ADDR_STATUS, rb);
        check("drain_status_0", 32'(rb), 32'h81);
        bus_write(ADDR_CMD, 8'h85);
        bus_read(ADDR_STATUS, rb);
        check("drain_status_1", 32'(rb), 32'h85);
        bus_read(ADDR_STATUS, rb);
        check("drain_status_2", 32'(rb), 32'h85);
        check("drain_no_restart", 32'(fpu_start), 32'd0);
        fpu_busy = 1'b0;
        @(negedge clk);
        bus_read(ADDR_STATUS, rb);
        check("drain_status_idle", 32'(rb), 32'h05);
        check("drain_start_idle", 32'(fpu_start), 32'd0);
        check("drain_op_kept", 32'(fpu_operation), 32'(FPU_DIV));
        read_word(ADDR_R0, rw);
        check("drain_result", rw, 32'h55556666);

        // reset in the middle of RUN
        bus_write(ADDR_CMD, 8'h80);
        fpu_busy = 1'b1;
        @(negedge clk);
        check("midreset_start_before", 32'(fpu_start), 32'd1);
        #2 arst = 1'b1;
        #1 check("midreset_start_async", 32'(fpu_start), 32'd0);
        @(negedge clk);
        arst = 1'b0; fpu_busy = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus_read(4'(k), rb);
            check($sformatf("midreset_read_%0d", k), 32'(rb), 32'd0);
        end
        bus_write(ADDR_CMD, 8'h80);
        run_fpu(2, 0, 32'h3f800000, sc, irq0, irq1);
        check("restart_start_cycles", 32'(sc), 32'd3);
        bus_read(ADDR_STATUS, rb);
        check("restart_status", 32'(rb), 32'h01);
        read_word(ADDR_R0, rw);
        check("restart_result", rw, 32'h3f800000);

        // randomized commands against the register model
        foreach (mem_m[k]) mem_m[k] = 8'h00;
        r_m = 32'h3f800000;
        for (int it = 0; it < 24; it++) begin
            logic        ie;
            logic        exp_to;
            int          nw;
            int          lat;
            int          hold;
            int          exp_start;
            logic [3:0]  wa;
            logic [7:0]  wd;
            logic [6:0]  opb;
            logic [31:0] res;
            ie = 1'($urandom_range(0, 1));
            bus_write(ADDR_STATUS, {4'b0000, ie, 3'b111});
            nw = $urandom_range(0, 6);
            for (int w = 0; w < nw; w++) begin
                wa = 4'($urandom_range(0, 13));
                if (wa == ADDR_CMD || wa == ADDR_STATUS) wa = wa + 4'd2;
                wd = 8'($urandom);
                bus_write(wa, wd);
                if (wa < 4'd8) mem_m[wa[2:0]] = wd;
            end
            check($sformatf("rnd%0d_a_operand", it), fpu_a_operand,
                  {mem_m[3], mem_m[2], mem_m[1], mem_m[0]});
            check($sformatf("rnd%0d_b_operand", it), fpu_b_operand,
                  {mem_m[7], mem_m[6], mem_m[5], mem_m[4]});
            opb  = 7'($urandom_range(0, 127));
            op_m = opb[3:0];
            lat  = $urandom_range(0, 20);
            hold = $urandom_range(0, 3);
            res  = $urandom;
            bus_write(ADDR_CMD, {1'b1, opb});
            check($sformatf("rnd%0d_operation", it), 32'(fpu_operation), 32'(op_m));
            run_fpu(lat, hold, res, sc, irq0, irq1);
            exp_to    = (lat + 1 > TO);
            exp_start = exp_to ? TO : lat + 1;
            if (!exp_to) r_m = res;
            check($sformatf("rnd%0d_start_cycles", it), 32'(sc), 32'(exp_start));
            check($sformatf("rnd%0d_irq_lag", it), 32'(irq0), 32'd0);
            check($sformatf("rnd%0d_irq", it), 32'(irq1), 32'(ie));
            read_word(ADDR_R0, rw);
            check($sformatf("rnd%0d_result", it), rw, r_m);
            bus_read(ADDR_STATUS, rb);
            check($sformatf("rnd%0d_status", it), 32'(rb), {28'd0, ie, 1'b0, exp_to, 1'b1});
            bus_read(4'(14 + (it % 2)), rb);
            check($sformatf("rnd%0d_reserved", it), 32'(rb), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
